// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    MT_BYTE = 2'b00,
    MT_HALF = 2'b01,
    MT_WORD = 2'b10
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } lsu_state_e;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // Encoding 2'b11 falls through to the word case.
  function automatic logic [3:0] byte_en(input logic [1:0] mt, input logic [1:0] a);
    case (mem_type_e'(mt))
      MT_BYTE: return 4'b0001 << a;
      MT_HALF: return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a raw 32-bit word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  output logic [31:0] result
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    byte_l = rdata[{a, 3'b000} +: 8];
    half_l = a[1] ? rdata[31:16] : rdata[15:0];
    case (mem_type_e'(mem_type))
      MT_BYTE: result = {{24{mem_sign & byte_l[7]}}, byte_l};
      MT_HALF: result = {{16{mem_sign & half_l[15]}}, half_l};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: turns EX/MEM controls into a req/ready/rvalid access and stalls until done.
// Optional macro LSU_MISALIGN_EXC_EN: trap misaligned half/word accesses instead of forcing alignment.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWriteM,
  input  logic                  MemSignM,
  input  logic [1:0]            ResultSrcM,
  input  logic [1:0]            MemTypeM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  BusErrM,
  output logic                  MisalignM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              access;
  logic              misalign_exc;
  logic              timeout_hit;
  logic [1:0]        a_eff;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_data;

  assign access = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign_exc = access &&
                        ((MemTypeM == MT_HALF && ALUResultM[0]) ||
                         (MemTypeM[1] && ALUResultM[1:0] != 2'b00));
  assign a_eff = ALUResultM[1:0];
`else
  assign misalign_exc = 1'b0;
  // Without the trap, low address bits are silently dropped to the access size.
  always_comb begin
    case (mem_type_e'(MemTypeM))
      MT_BYTE: a_eff = ALUResultM[1:0];
      MT_HALF: a_eff = {ALUResultM[1], 1'b0};
      default: a_eff = 2'b00;
    endcase
  end
`endif

  always_comb begin
    case (mem_type_e'(MemTypeM))
      MT_BYTE: wdata_rep = {4{WriteDataM[7:0]}};
      MT_HALF: wdata_rep = {2{WriteDataM[15:0]}};
      default: wdata_rep = WriteDataM;
    endcase
  end

  lsu_load_align u_align (
    .rdata    (dmem_rdata),
    .a        (a_eff),
    .mem_type (MemTypeM),
    .mem_sign (MemSignM),
    .result   (load_data)
  );

  // Request/stall decode depends on the live M inputs so the first IDLE cycle already stalls.
  assign dmem_req   = !rst && (state == S_IDLE) && access && !misalign_exc;
  assign StallM     = !rst && (((state == S_IDLE) && access) || (state == S_WAIT));
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = dmem_req ? {ALUResultM[31:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? byte_en(MemTypeM, a_eff) : 4'b0000;
  assign dmem_wdata = dmem_req ? wdata_rep : '0;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
    end else begin
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (misalign_exc) begin
            state     <= S_DONE;
            MisalignM <= 1'b1;
            ReadDataM <= '0;
          end else if (access && dmem_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            state <= S_DONE;
            cnt   <= '0;
            if (!MemWriteM) ReadDataM <= load_data;
          end else if (timeout_hit) begin
            state     <= S_DONE;
            cnt       <= '0;
            BusErrM   <= 1'b1;
            ReadDataM <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // One unstalled cycle lets the pipeline retire this access.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of minimum-latency accesses plus multi-cycle corner sequences.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM, MemSignM;
  logic [1:0]  ResultSrcM, MemTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic [31:0] rd0, addr0, wdata0;
  logic        stall0, buserr0, mis0, req0, we0;
  logic [3:0]  be0;
  logic [31:0] rd1, addr1, wdata1;
  logic        stall1, buserr1, mis1, req1, we1;
  logic [3:0]  be1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) u0 (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemSignM(MemSignM),
    .ResultSrcM(ResultSrcM), .MemTypeM(MemTypeM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(rd0), .StallM(stall0), .BusErrM(buserr0),
    .MisalignM(mis0), .dmem_req(req0), .dmem_we(we0), .dmem_addr(addr0),
    .dmem_wdata(wdata0), .dmem_be(be0), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemSignM(MemSignM),
    .ResultSrcM(ResultSrcM), .MemTypeM(MemTypeM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(rd1), .StallM(stall1), .BusErrM(buserr1),
    .MisalignM(mis1), .dmem_req(req1), .dmem_we(we1), .dmem_addr(addr1),
    .dmem_wdata(wdata1), .dmem_be(be1), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        we;
    logic        sgn;
    logic [1:0]  rs;
    logic [1:0]  mt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic we, input logic sgn, input logic [1:0] rs,
                       input logic [1:0] mt, input logic [31:0] a, input logic [31:0] wd);
    MemWriteM  = we;
    MemSignM   = sgn;
    ResultSrcM = rs;
    MemTypeM   = mt;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  // Minimum-latency access: ready in the IDLE cycle, rvalid in the first WAIT cycle.
  task automatic run_vec(input vec_t v, input string tag);
    tick();
    drive(v.we, v.sgn, v.rs, v.mt, v.a, v.wd);
    dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    settle();
    chk({tag, " req"},   32'(req0),   32'd1);
    chk({tag, " stall1"}, 32'(stall0), 32'd1);
    chk({tag, " we"},    32'(we0),    32'(v.we));
    chk({tag, " addr"},  addr0,       v.a & 32'hFFFF_FFFC);
    chk({tag, " be"},    32'(be0),    32'(v.be));
    chk({tag, " wdata"}, wdata0,      v.ewd);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
    settle();
    chk({tag, " stall2"}, 32'(stall0), 32'd1);
    chk({tag, " req_wait"}, 32'(req0), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    settle();
    chk({tag, " stall_done"}, 32'(stall0), 32'd0);
    chk({tag, " rdata"},  rd0,         v.erd);
    chk({tag, " buserr"}, 32'(buserr0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         we   sgn  rs     mt     a             wd            rdata         be       ewd           erd
    vt[0] = '{1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_0103, 32'h1122_3344, 32'h80FF_FF00, 4'b1000, 32'h4444_4444, 32'hFFFF_FF80};
    vt[1] = '{1'b0, 1'b0, 2'b01, 2'b00, 32'h0000_0101, 32'h0000_0000, 32'h1234_80AB, 4'b0010, 32'h0000_0000, 32'h0000_0080};
    vt[2] = '{1'b0, 1'b1, 2'b01, 2'b01, 32'h0000_0202, 32'h0000_0000, 32'h8001_7FFF, 4'b1100, 32'h0000_0000, 32'hFFFF_8001};
    vt[3] = '{1'b0, 1'b0, 2'b01, 2'b01, 32'h0000_0200, 32'h0000_0000, 32'h8001_F00D, 4'b0011, 32'h0000_0000, 32'h0000_F00D};
    vt[4] = '{1'b0, 1'b1, 2'b01, 2'b10, 32'h0000_0300, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 1'b0, 2'b00, 2'b01, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 4'b1100, 32'hABCD_ABCD, 32'hDEAD_BEEF};
    vt[6] = '{1'b1, 1'b0, 2'b00, 2'b00, 32'h0000_0001, 32'h0000_00A5, 32'h5555_5555, 4'b0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vt[7] = '{1'b1, 1'b0, 2'b00, 2'b10, 32'h0000_0404, 32'hCAFE_F00D, 32'h5555_5555, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vt[8] = '{1'b0, 1'b0, 2'b01, 2'b11, 32'h0000_0010, 32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0000_0000, 32'h0102_0304};
    vt[9] = '{1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_0102, 32'h0000_0000, 32'h007F_0000, 4'b0100, 32'h0000_0000, 32'h0000_007F};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    settle();
    chk("reset stall", 32'(stall0), 32'd0);
    chk("reset req",   32'(req0),   32'd0);
    chk("reset rdata", rd0,         32'd0);
    chk("reset buserr", 32'(buserr0), 32'd0);
    chk("reset misalign", 32'(mis0), 32'd0);
    chk("reset be",    32'(be0),    32'd0);
    chk("reset addr",  addr0,       32'd0);
    chk("reset wdata", wdata0,      32'd0);
    tick();
    rst = 1'b0;
    // Non-access with a live address: nothing must leave the unit.
    drive(1'b0, 1'b0, 2'b10, 2'b10, 32'h0000_0700, 32'hFFFF_FFFF);
    dmem_ready = 1'b1;
    settle();
    chk("noacc stall", 32'(stall0), 32'd0);
    chk("noacc req",   32'(req0),   32'd0);
    chk("noacc addr",  addr0,       32'd0);
    chk("noacc wdata", wdata0,      32'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Timeout on the short-timeout instance; the default one keeps waiting.
    tick();
    drive(1'b0, 1'b0, 2'b01, 2'b10, 32'h0000_0600, 32'h0);
    dmem_ready = 1'b1;
    settle();
    chk("to req", 32'(req1), 32'd1);
    tick();
    dmem_ready = 1'b0;
    settle();
    chk("to wait0 stall", 32'(stall1), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      settle();
      chk($sformatf("to wait%0d stall", k), 32'(stall1), 32'd1);
      chk($sformatf("to wait%0d buserr", k), 32'(buserr1), 32'd0);
    end
    tick();
    settle();
    chk("to done stall",  32'(stall1),  32'd0);
    chk("to done buserr", 32'(buserr1), 32'd1);
    chk("to done rdata",  rd1,          32'd0);
    chk("to long stall",  32'(stall0),  32'd1);
    tick();
    settle();
    chk("to buserr pulse", 32'(buserr1), 32'd0);
    chk("to long stall2",  32'(stall0),  32'd1);

    // Reset while the default instance sits in WAIT, with a response arriving.
    rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    settle();
    chk("rst wait stall", 32'(stall0), 32'd0);
    chk("rst wait req",   32'(req0),   32'd0);
    chk("rst wait rdata", rd0,         32'd0);
    chk("rst wait be",    32'(be0),    32'd0);
    chk("rst wait addr",  addr0,       32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    settle();
    chk("stale stall", 32'(stall0), 32'd0);
    tick();
    settle();
    chk("stale rdata",  rd0,          32'd0);
    chk("stale buserr", 32'(buserr0), 32'd0);
    chk("stale stall2", 32'(stall0),  32'd0);
    dmem_rvalid = 1'b0;

    // LW with ready low 3 cycles (stale rvalid ignored in IDLE), rvalid in the 5th WAIT cycle.
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1'b0, 1'b0, 2'b01, 2'b10, 32'h0000_0500, 32'h0);
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
      settle();
      chk($sformatf("slow idle%0d req", k),   32'(req0),   32'd1);
      chk($sformatf("slow idle%0d addr", k),  addr0,       32'h0000_0500);
      chk($sformatf("slow idle%0d stall", k), 32'(stall0), 32'd1);
    end
    tick();
    dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    settle();
    chk("slow accept req", 32'(req0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      dmem_ready = 1'b0;
      settle();
      chk($sformatf("slow wait%0d stall", k), 32'(stall0), 32'd1);
      chk($sformatf("slow wait%0d req", k),   32'(req0),   32'd0);
    end
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    settle();
    chk("slow wait4 stall", 32'(stall0), 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    settle();
    chk("slow done stall", 32'(stall0), 32'd0);
    chk("slow done rdata", rd0,         32'h1357_9BDF);

    // Misaligned word load at 0x101.
    tick();
    drive(1'b0, 1'b0, 2'b01, 2'b10, 32'h0000_0101, 32'h0);
    dmem_ready = 1'b1;
    settle();
`ifdef LSU_MISALIGN_EXC_EN
    chk("mis req",   32'(req0),   32'd0);
    chk("mis stall", 32'(stall0), 32'd1);
    tick();
    dmem_ready = 1'b0;
    settle();
    chk("mis done stall", 32'(stall0), 32'd0);
    chk("mis done flag",  32'(mis0),   32'd1);
    chk("mis done rdata", rd0,         32'd0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    settle();
    chk("mis pulse", 32'(mis0), 32'd0);
`else
    chk("mis req",  32'(req0),  32'd1);
    chk("mis addr", addr0,      32'h0000_0100);
    chk("mis be",   32'(be0),   32'hF);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    settle();
    chk("mis wait stall", 32'(stall0), 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    settle();
    chk("mis done rdata", rd0,         32'h0BAD_F00D);
    chk("mis done flag",  32'(mis0),   32'd0);
    chk("mis done stall", 32'(stall0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
